tv80_dma: RTL and testbench

Single-channel DMA controller for the TV80 test environment. The CPU programs it through a bank of I/O-mapped registers. It then takes the Z80 bus with the `busrq_n`/`busak_n` handshake and moves a block of bytes as bus initiator. Sources are always memory; the destination is memory or an I/O port. It sits beside `env_io` on the I/O decode, and its master outputs are muxed onto the CPU address, data and strobe nets while `dma_oe` is high.

---
 rtl/tv80_dma_pkg.sv | 54 +++++
 rtl/tv80_dma_regs.sv | 135 +++++++++++++
 rtl/tv80_dma.sv | 171 +++++++++++++++++
 tb/tb_tv80_dma.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv80_dma_pkg.sv
// tv80_dma_pkg: shared types and constants for the TV80 single-channel DMA.
// Optional feature macro: TV80_DMA_IRQ_EN (completion interrupt).
package tv80_dma_pkg;

    // Transfer sequencer states, one bus phase per state.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_WR1,
        ST_WR2,
        ST_WR3,
        ST_REL
    } dma_state_t;

    // Register offsets from IO_BASE.
    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    // CTRL bit positions.
    localparam int CTRL_START     = 0;
    localparam int CTRL_DST_IO    = 1;
    localparam int CTRL_DST_FIXED = 2;
    localparam int CTRL_IRQ_EN    = 3;

    // STATUS bit positions.
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    // Programmed transfer descriptor as seen by the sequencer.
    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic        dst_io;
        logic        dst_fixed;
    } dma_cfg_t;

    // Post-byte counter values written back into the register file.
    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
    } dma_upd_t;

endpackage

// File: rtl/tv80_dma_regs.sv
// tv80_dma_regs: I/O slave decode, register file, strobe edge-detect,
// read mux and sticky DONE. Optional feature macro: TV80_DMA_IRQ_EN.
module tv80_dma_regs
    import tv80_dma_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] cpu_do,
    output logic [7:0] cfg_di,
    output logic       cfg_oe,
    input  logic       busy,
    input  logic       done_set,
    input  logic       upd_en,
    input  dma_upd_t   upd,
    output dma_cfg_t   cfg,
    output logic       start,
    output logic       int_n
);

    logic        hit, wr_act, rd_act, wr_act_q, rd_act_q;
    logic        wr_fire, rd_fire;
    logic [15:0] src_q, dst_q, len_q;
    logic        dst_io_q, dst_fixed_q, done_q, irq_en_q;
    logic [7:0]  rd_mux, rd_hold_q;

    assign hit    = (addr[7:3] == IO_BASE[7:3]);
    assign wr_act = ~iorq_n & ~wr_n & hit;
    assign rd_act = ~iorq_n & ~rd_n & hit;

    // A write lands only on the first clock of its strobe, and never while a
    // transfer owns the counters.
    assign wr_fire = wr_act & ~wr_act_q & ~busy;
    assign rd_fire = rd_act & ~rd_act_q;
    assign start   = wr_fire & (addr[2:0] == REG_CTRL) & cpu_do[CTRL_START];

    // Strobe history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_act_q <= 1'b0;
            rd_act_q <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            rd_act_q <= rd_act;
        end
    end

    // Register file: CPU writes when idle, sequencer write-back per byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q       <= 16'h0000;
            dst_q       <= 16'h0000;
            len_q       <= 16'h0000;
            dst_io_q    <= 1'b0;
            dst_fixed_q <= 1'b0;
        end else if (wr_fire) begin
            case (addr[2:0])
                REG_SRC_LO: src_q[7:0]  <= cpu_do;
                REG_SRC_HI: src_q[15:8] <= cpu_do;
                REG_DST_LO: dst_q[7:0]  <= cpu_do;
                REG_DST_HI: dst_q[15:8] <= cpu_do;
                REG_LEN_LO: len_q[7:0]  <= cpu_do;
                REG_LEN_HI: len_q[15:8] <= cpu_do;
                REG_CTRL: begin
                    dst_io_q    <= cpu_do[CTRL_DST_IO];
                    dst_fixed_q <= cpu_do[CTRL_DST_FIXED];
                end
                default: ;
            endcase
        end else if (upd_en) begin
            src_q <= upd.src;
            dst_q <= upd.dst;
            len_q <= upd.len;
        end
    end

`ifdef TV80_DMA_IRQ_EN
    // Interrupt enable storage, written with the rest of CTRL.
    always_ff @(posedge clk) begin
        if (reset)
            irq_en_q <= 1'b0;
        else if (wr_fire && addr[2:0] == REG_CTRL)
            irq_en_q <= cpu_do[CTRL_IRQ_EN];
    end
    assign int_n = ~(done_q & irq_en_q);
`else
    assign irq_en_q = 1'b0;
    assign int_n    = 1'b1;
`endif

    // Sticky DONE; a completion in the same cycle as the clearing read wins.
    always_ff @(posedge clk) begin
        if (reset)
            done_q <= 1'b0;
        else if (done_set)
            done_q <= 1'b1;
        else if (rd_fire && addr[2:0] == REG_STATUS)
            done_q <= 1'b0;
    end

    // Read mux over the live register state.
    always_comb begin
        rd_mux = 8'h00;
        case (addr[2:0])
            REG_SRC_LO: rd_mux = src_q[7:0];
            REG_SRC_HI: rd_mux = src_q[15:8];
            REG_DST_LO: rd_mux = dst_q[7:0];
            REG_DST_HI: rd_mux = dst_q[15:8];
            REG_LEN_LO: rd_mux = len_q[7:0];
            REG_LEN_HI: rd_mux = len_q[15:8];
            REG_CTRL:   rd_mux = {4'b0000, irq_en_q, dst_fixed_q, dst_io_q, 1'b0};
            REG_STATUS: rd_mux = {6'b000000, done_q, busy};
            default:    rd_mux = 8'h00;
        endcase
    end

    // Snapshot on the first strobe cycle so a long read keeps returning the
    // pre-clear STATUS value.
    always_ff @(posedge clk) begin
        if (reset)
            rd_hold_q <= 8'h00;
        else if (rd_fire)
            rd_hold_q <= rd_mux;
    end

    assign cfg_oe = rd_act;
    assign cfg_di = rd_act ? (rd_act_q ? rd_hold_q : rd_mux) : 8'h00;
    assign cfg    = '{src_q, dst_q, len_q, dst_io_q, dst_fixed_q};

endmodule

// File: rtl/tv80_dma.sv
// tv80_dma: single-channel Z80 bus-master DMA. Holds the transfer
// sequencer, per-byte counter arithmetic and master bus outputs.
// Optional feature macro: TV80_DMA_IRQ_EN (completion interrupt on int_n).
module tv80_dma
    import tv80_dma_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cfg_di,
    output logic        cfg_oe,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic        wait_n,
    output logic [15:0] dma_A,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di,
    output logic        dma_mreq_n,
    output logic        dma_iorq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n,
    output logic        dma_oe,
    output logic        int_n
);

    dma_state_t  state_q, state_d;
    dma_cfg_t    cfg;
    dma_upd_t    upd;
    logic        start, busy, done_set, upd_en;
    logic [7:0]  data_q;
    logic [15:0] wr_addr;

    assign busy = (state_q != ST_IDLE);

    tv80_dma_regs #(.IO_BASE(IO_BASE)) u_regs (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .cpu_do   (cpu_do),
        .cfg_di   (cfg_di),
        .cfg_oe   (cfg_oe),
        .busy     (busy),
        .done_set (done_set),
        .upd_en   (upd_en),
        .upd      (upd),
        .cfg      (cfg),
        .start    (start),
        .int_n    (int_n)
    );

    // Counter arithmetic is plain 16-bit modulo; LEN only decrements from a
    // non-zero value, so it never wraps.
    assign upd = '{cfg.src + 16'd1,
                   cfg.dst_fixed ? cfg.dst : cfg.dst + 16'd1,
                   cfg.len - 16'd1};

    // I/O destinations drive the port number on the low address byte only.
    assign wr_addr = cfg.dst_io ? {8'h00, cfg.dst[7:0]} : cfg.dst;
    assign dma_do  = data_q;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Read data is captured at the end of the last read phase.
    always_ff @(posedge clk) begin
        if (reset)
            data_q <= 8'h00;
        else if (state_q == ST_RD3)
            data_q <= dma_di;
    end

    // Next-state and bus outputs, decoded from the current phase.
    always_comb begin
        state_d    = state_q;
        done_set   = 1'b0;
        upd_en     = 1'b0;
        busrq_n    = 1'b1;
        dma_oe     = 1'b0;
        dma_mreq_n = 1'b1;
        dma_iorq_n = 1'b1;
        dma_rd_n   = 1'b1;
        dma_wr_n   = 1'b1;
        dma_A      = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg.len != 16'h0000)
                        state_d = ST_REQ;
                    else
                        done_set = 1'b1;
                end
            end
            ST_REQ: begin
                busrq_n = 1'b0;
                if (!busak_n)
                    state_d = ST_RD1;
            end
            ST_RD1: begin
                busrq_n = 1'b0;
                dma_oe  = 1'b1;
                dma_A   = cfg.src;
                state_d = ST_RD2;
            end
            ST_RD2: begin
                busrq_n    = 1'b0;
                dma_oe     = 1'b1;
                dma_A      = cfg.src;
                dma_mreq_n = 1'b0;
                dma_rd_n   = 1'b0;
                if (wait_n)
                    state_d = ST_RD3;
            end
            ST_RD3: begin
                busrq_n    = 1'b0;
                dma_oe     = 1'b1;
                dma_A      = cfg.src;
                dma_mreq_n = 1'b0;
                dma_rd_n   = 1'b0;
                state_d    = ST_WR1;
            end
            ST_WR1: begin
                busrq_n = 1'b0;
                dma_oe  = 1'b1;
                dma_A   = wr_addr;
                state_d = ST_WR2;
            end
            ST_WR2: begin
                busrq_n    = 1'b0;
                dma_oe     = 1'b1;
                dma_A      = wr_addr;
                dma_mreq_n = cfg.dst_io;
                dma_iorq_n = ~cfg.dst_io;
                dma_wr_n   = 1'b0;
                if (wait_n)
                    state_d = ST_WR3;
            end
            ST_WR3: begin
                busrq_n    = 1'b0;
                dma_oe     = 1'b1;
                dma_A      = wr_addr;
                dma_mreq_n = cfg.dst_io;
                dma_iorq_n = ~cfg.dst_io;
                dma_wr_n   = 1'b0;
                upd_en     = 1'b1;
                state_d    = (upd.len != 16'h0000) ? ST_RD1 : ST_REL;
            end
            ST_REL: begin
                if (busak_n) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tv80_dma.sv
// tb_tv80_dma: directed bench with a bus-cycle scoreboard. Expected master
// reads/writes are queued when a transfer is programmed and popped as the
// DMA strobes appear on the bus.
module tb_tv80_dma;

    typedef struct packed {
        logic        io;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        iorq_n, rd_n, wr_n;
    logic [7:0]  cpu_do;
    logic [7:0]  cfg_di;
    logic        cfg_oe;
    logic        busrq_n;
    logic        busak_n;
    logic        wait_n;
    logic [15:0] dma_A;
    logic [7:0]  dma_do;
    logic [7:0]  dma_di;
    logic        dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n;
    logic        dma_oe;
    logic        int_n;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rd [$];
    wr_t         exp_wr [$];
    int          checks = 0;
    int          errors = 0;
    int          busrq_low = 0;
    int          oe_cnt = 0;
    int          rd_waits = 0;
    logic        prev_rd_n = 1'b1;
    logic        prev_wr_n = 1'b1;
    logic [7:0]  rv;

    tv80_dma #(.IO_BASE(8'h80)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .cpu_do     (cpu_do),
        .cfg_di     (cfg_di),
        .cfg_oe     (cfg_oe),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .wait_n     (wait_n),
        .dma_A      (dma_A),
        .dma_do     (dma_do),
        .dma_di     (dma_di),
        .dma_mreq_n (dma_mreq_n),
        .dma_iorq_n (dma_iorq_n),
        .dma_rd_n   (dma_rd_n),
        .dma_wr_n   (dma_wr_n),
        .dma_oe     (dma_oe),
        .int_n      (int_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score bus cycles, then play the
    // CPU/memory side (bus grant follows request, read data, wait states).
    task automatic tick();
        wr_t e, o;
        @(negedge clk);
        if (!dma_rd_n && prev_rd_n) begin
            check("rd_q_nonempty", 32'(exp_rd.size() != 0), 32'h1);
            if (exp_rd.size() != 0) begin
                check("rd_addr", 32'(dma_A), 32'(exp_rd.pop_front()));
                check("rd_mreq", 32'(dma_mreq_n), 32'h0);
            end
        end
        if (!dma_wr_n && prev_wr_n) begin
            check("wr_q_nonempty", 32'(exp_wr.size() != 0), 32'h1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                o = '{~dma_iorq_n, dma_A, dma_do};
                check("wr_kind", 32'({dma_mreq_n, dma_iorq_n}), e.io ? 32'h2 : 32'h1);
                check("wr_addr_data", 32'(o), 32'(e));
            end
        end
        if (!busrq_n) busrq_low++;
        if (dma_oe) oe_cnt++;
        prev_rd_n = dma_rd_n;
        prev_wr_n = dma_wr_n;
        busak_n = busrq_n;
        dma_di = mem[dma_A];
        if (!dma_rd_n && rd_waits > 0) begin
            wait_n = 1'b0;
            rd_waits--;
        end else begin
            wait_n = 1'b1;
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; cpu_do = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick(); tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
    endtask

    task automatic io_read(input logic [2:0] off, output logic [7:0] d);
        addr = {5'b10000, off}; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        d = cfg_di;
        check("cfg_oe", 32'(cfg_oe), 32'h1);
        tick(); tick();
        iorq_n = 1'b1; rd_n = 1'b1;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        io_read(off, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        io_write(8'h80, s[7:0]);  io_write(8'h81, s[15:8]);
        io_write(8'h82, d[7:0]);  io_write(8'h83, d[15:8]);
        io_write(8'h84, n[7:0]);  io_write(8'h85, n[15:8]);
    endtask

    task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                             input logic io, input logic fixed);
        logic [15:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = s + 16'(i);
            da = fixed ? d : d + 16'(i);
            if (io) da = {8'h00, da[7:0]};
            exp_rd.push_back(sa);
            exp_wr.push_back('{io, da, mem[sa]});
        end
    endtask

    task automatic wait_busrq(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (busrq_n !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busrq_n), 32'(lvl));
    endtask

    task automatic run_done();
        wait_busrq(1'b0, 10, "req_timeout");
        wait_busrq(1'b1, 400, "rel_timeout");
        tick(); tick();
        check("rd_q_drained", 32'(exp_rd.size()), 32'h0);
        check("wr_q_drained", 32'(exp_wr.size()), 32'h0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) + (i >> 8) + 5);
        reset = 1'b1; addr = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        cpu_do = 8'h00; busak_n = 1'b1; wait_n = 1'b1; dma_di = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_busrq_n", 32'(busrq_n), 32'h1);
        check("rst_dma_oe", 32'(dma_oe), 32'h0);
        check("rst_strobes", 32'({dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n}), 32'hF);
        check("rst_dma_A", 32'(dma_A), 32'h0);
        check("rst_dma_do", 32'(dma_do), 32'h0);
        check("rst_cfg_di", 32'(cfg_di), 32'h0);
        check("rst_cfg_oe", 32'(cfg_oe), 32'h0);
        check("rst_int_n", 32'(int_n), 32'h1);
        rd_chk("rst_status", 3'd7, 8'h00);
        rd_chk("rst_len_hi", 3'd5, 8'h00);

        // Memory to memory copy, no waits
        prog(16'h8000, 16'h8100, 16'd4);
        push_xfer(16'h8000, 16'h8100, 4, 1'b0, 1'b0);
        busrq_low = 0;
        io_write(8'h86, 8'h01);
        run_done();
        check("m2m_busrq_cycles", 32'(busrq_low), 32'd25);
        check("m2m_int_n", 32'(int_n), 32'h1);
        rd_chk("m2m_status_done", 3'd7, 8'h02);
        rd_chk("m2m_status_clr", 3'd7, 8'h00);

        // Three wait states in the first read
        prog(16'h8200, 16'h8300, 16'd1);
        push_xfer(16'h8200, 16'h8300, 1, 1'b0, 1'b0);
        rd_waits = 3;
        oe_cnt = 0;
        io_write(8'h86, 8'h01);
        run_done();
        check("wait_byte_clocks", 32'(oe_cnt), 32'd9);

        // Source address wrap
        prog(16'hFFFE, 16'h8400, 16'd3);
        push_xfer(16'hFFFE, 16'h8400, 3, 1'b0, 1'b0);
        io_write(8'h86, 8'h01);
        run_done();
        rd_chk("wrap_src_lo", 3'd0, 8'h01);
        rd_chk("wrap_src_hi", 3'd1, 8'h00);
        rd_chk("wrap_dst_lo", 3'd2, 8'h03);
        rd_chk("wrap_len_lo", 3'd4, 8'h00);

        // I/O destination, fixed port
        prog(16'h8000, 16'h0010, 16'd2);
        push_xfer(16'h8000, 16'h0010, 2, 1'b1, 1'b1);
        io_write(8'h86, 8'h07);
        run_done();
        rd_chk("io_ctrl_readback", 3'd6, 8'h06);
        rd_chk("io_dst_fixed", 3'd2, 8'h10);
        rd_chk("io_src_lo", 3'd0, 8'h02);

        // Address outside the register bank is ignored
        io_write(8'h40, 8'h77);
        rd_chk("miss_src_lo", 3'd0, 8'h02);

        // START with LEN=0
        prog(16'h8000, 16'h8800, 16'd0);
        busrq_low = 0;
        io_write(8'h86, 8'h01);
        tick(); tick(); tick();
        check("len0_no_busrq", 32'(busrq_low), 32'h0);
        rd_chk("len0_status", 3'd7, 8'h02);

        // Register write while busy
        prog(16'h8000, 16'h8500, 16'd2);
        push_xfer(16'h8000, 16'h8500, 2, 1'b0, 1'b0);
        io_write(8'h86, 8'h01);
        io_write(8'h80, 8'h55);
        rd_chk("busy_status", 3'd7, 8'h01);
        run_done();
        rd_chk("busy_src_lo", 3'd0, 8'h02);
        rd_chk("busy_src_hi", 3'd1, 8'h80);

        // Reset asserted in WR2
        prog(16'h8000, 16'h8600, 16'd2);
        push_xfer(16'h8000, 16'h8600, 2, 1'b0, 1'b0);
        io_write(8'h86, 8'h01);
        n = 0;
        while (dma_wr_n !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("rst_mid_reach_wr2", 32'(dma_wr_n), 32'h0);
        reset = 1'b1;
        tick();
        check("rst_mid_busrq_n", 32'(busrq_n), 32'h1);
        check("rst_mid_dma_oe", 32'(dma_oe), 32'h0);
        check("rst_mid_strobes", 32'({dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n}), 32'hF);
        check("rst_mid_dma_A", 32'(dma_A), 32'h0);
        reset = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        tick();
        rd_chk("rst_mid_src_hi", 3'd1, 8'h00);
        rd_chk("rst_mid_status", 3'd7, 8'h00);

        // Completion interrupt
        prog(16'h8000, 16'h8700, 16'd1);
        push_xfer(16'h8000, 16'h8700, 1, 1'b0, 1'b0);
        io_write(8'h86, 8'h09);
        run_done();
`ifdef TV80_DMA_IRQ_EN
        check("irq_int_low", 32'(int_n), 32'h0);
        rd_chk("irq_ctrl", 3'd6, 8'h08);
        rd_chk("irq_status", 3'd7, 8'h02);
        check("irq_int_released", 32'(int_n), 32'h1);
`else
        check("irq_int_tied", 32'(int_n), 32'h1);
        rd_chk("irq_ctrl", 3'd6, 8'h00);
        rd_chk("irq_status", 3'd7, 8'h02);
        check("irq_int_after", 32'(int_n), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
